video_led_seq: RTL and testbench

VIDEO_LED_SEQ -- requirements
Module: video_led_seq

---
 rtl/video_led_seq_pkg.sv | 18 +
 rtl/video_led_seq_auto.sv | 42 ++++
 rtl/video_led_seq.sv | 114 +++++++++++
 tb/tb_video_led_seq.sv | 212 +++++++++++++++++++++
 4 files changed

// File: rtl/video_led_seq_pkg.sv
// Shared definitions for the video LED sequencer: LED vector width,
// sequencer state encodings and the walking-LED rotate helper.
package video_led_seq_pkg;

  localparam int LED_W = 18;

  typedef enum logic [1:0] {
    ST_IDLE      = 2'd0,
    ST_HOST_PEND = 2'd1,
    ST_AUTO_PEND = 2'd2
  } seq_state_t;

  // Rotate an LED vector left by one position; the MSB wraps to bit 0.
  function automatic logic [LED_W-1:0] rotl1(input logic [LED_W-1:0] v);
    return {v[LED_W-2:0], v[LED_W-1]};
  endfunction

endpackage

// File: rtl/video_led_seq_auto.sv
// Autonomous walking-LED source: counts frame strobes while enabled and
// raises a one-cycle trigger every C_AUTO_PERIOD frames, together with the
// next pattern derived from the currently committed LED vector.
module video_led_seq_auto
  import video_led_seq_pkg::*;
#(
  parameter logic [7:0] C_AUTO_PERIOD = 8'd30
) (
  input  logic             i_clk,
  input  logic             i_rst_n,
  input  logic             i_ce,
  input  logic             i_hvcy,
  input  logic             i_auto_en,
  input  logic [LED_W-1:0] i_leds,
  output logic             o_trig,
  output logic [LED_W-1:0] o_pattern
);

  logic [7:0] r_fctr;
  logic       w_wrap;

  assign w_wrap = (r_fctr == (C_AUTO_PERIOD - 8'd1));

  // Frame counter: cleared while auto mode is off, wraps at the period.
  always_ff @(posedge i_clk or negedge i_rst_n) begin
    if (!i_rst_n) begin
      r_fctr <= 8'd0;
    end else if (i_ce) begin
      if (!i_auto_en) begin
        r_fctr <= 8'd0;
      end else if (i_hvcy) begin
        r_fctr <= w_wrap ? 8'd0 : (r_fctr + 8'd1);
      end
    end
  end

  // The trigger is combinational so the sequencer can resolve it against a
  // commit happening on the very same strobe.
  assign o_trig    = i_ce & i_auto_en & i_hvcy & w_wrap;
  assign o_pattern = (i_leds == '0) ? {{(LED_W-1){1'b0}}, 1'b1} : rotl1(i_leds);

endmodule

// File: rtl/video_led_seq.sv
// Video LED sequencer: accepts host LED updates or autonomous walking-LED
// steps into a shadow register and commits them to the video LED vector
// only on a frame-end strobe, so the displayed LEDs never tear mid-frame.
module video_led_seq
  import video_led_seq_pkg::*;
#(
  parameter logic [7:0]       C_AUTO_PERIOD = 8'd30,
  parameter logic [LED_W-1:0] C_INIT_LEDS   = 18'h00000
) (
  input  logic             CK_i,
  input  logic             XARST_i,
  input  logic             CK_EE_i,
  input  logic             HVcy_i,
  input  logic             AUTO_EN_i,
  input  logic             HREQ_i,
  input  logic [LED_W-1:0] HLEDs_i,
  output logic             HACK_o,
  output logic [LED_W-1:0] LEDs_ON_o,
  output logic             COMMIT_o,
  output logic             PEND_o,
  output logic [7:0]       DROPs_o
);

  seq_state_t       r_state;
  logic [LED_W-1:0] r_shadow;
  logic [LED_W-1:0] r_leds;
  logic [7:0]       r_drops;
  logic             r_hack;
  logic             r_commit;

  logic             w_trig;
  logic [LED_W-1:0] w_pattern;

  // Saturating increment for the discarded-update counter.
  function automatic logic [7:0] sat_inc8(input logic [7:0] v);
    return (v == 8'hFF) ? v : (v + 8'd1);
  endfunction

  video_led_seq_auto #(
    .C_AUTO_PERIOD (C_AUTO_PERIOD)
  ) u_auto (
    .i_clk     (CK_i),
    .i_rst_n   (XARST_i),
    .i_ce      (CK_EE_i),
    .i_hvcy    (HVcy_i),
    .i_auto_en (AUTO_EN_i),
    .i_leds    (r_leds),
    .o_trig    (w_trig),
    .o_pattern (w_pattern)
  );

  // Sequencer FSM: owns the shadow, committed LEDs, drop counter and pulses.
  always_ff @(posedge CK_i or negedge XARST_i) begin
    if (!XARST_i) begin
      r_state  <= ST_IDLE;
      r_shadow <= '0;
      r_leds   <= C_INIT_LEDS;
      r_drops  <= 8'd0;
      r_hack   <= 1'b0;
      r_commit <= 1'b0;
    end else if (CK_EE_i) begin
      r_hack   <= 1'b0;
      r_commit <= 1'b0;
      case (r_state)
        ST_IDLE: begin
          // A host request wins over a simultaneous auto step; a strobe in
          // the same cycle only captures, the commit waits a full frame.
          if (HREQ_i) begin
            r_shadow <= HLEDs_i;
            r_state  <= ST_HOST_PEND;
            r_hack   <= 1'b1;
            if (w_trig) r_drops <= sat_inc8(r_drops);
          end else if (w_trig) begin
            r_shadow <= w_pattern;
            r_state  <= ST_AUTO_PEND;
          end
        end
        ST_HOST_PEND: begin
          if (HVcy_i) begin
            r_leds   <= r_shadow;
            r_commit <= 1'b1;
            r_state  <= ST_IDLE;
          end
          // Auto steps never displace a pending host value.
          if (w_trig) r_drops <= sat_inc8(r_drops);
        end
        ST_AUTO_PEND: begin
          if (HREQ_i) begin
            r_shadow <= HLEDs_i;
            r_state  <= ST_HOST_PEND;
            r_hack   <= 1'b1;
            r_drops  <= sat_inc8(r_drops);
          end else if (!AUTO_EN_i) begin
            r_state <= ST_IDLE;
          end else if (HVcy_i) begin
            // A trigger on this same strobe is deliberately not re-armed.
            r_leds   <= r_shadow;
            r_commit <= 1'b1;
            r_state  <= ST_IDLE;
          end
        end
        default: r_state <= ST_IDLE;
      endcase
    end
  end

  // Pulses are held across disabled cycles and shown on the next active one.
  assign HACK_o    = r_hack & CK_EE_i;
  assign COMMIT_o  = r_commit & CK_EE_i;
  assign PEND_o    = (r_state != ST_IDLE);
  assign LEDs_ON_o = r_leds;
  assign DROPs_o   = r_drops;

endmodule

// File: tb/tb_video_led_seq.sv
// Directed bench for video_led_seq with a short auto period of 2 frames.
module tb_video_led_seq;

  logic        CK_i = 1'b0;
  logic        XARST_i = 1'b0;
  logic        CK_EE_i = 1'b1;
  logic        HVcy_i = 1'b0;
  logic        AUTO_EN_i = 1'b0;
  logic        HREQ_i = 1'b0;
  logic [17:0] HLEDs_i = 18'h0;
  logic        HACK_o;
  logic [17:0] LEDs_ON_o;
  logic        COMMIT_o;
  logic        PEND_o;
  logic [7:0]  DROPs_o;

  int checks = 0;
  int errors = 0;

  video_led_seq #(
    .C_AUTO_PERIOD (8'd2),
    .C_INIT_LEDS   (18'h00000)
  ) dut (
    .CK_i      (CK_i),
    .XARST_i   (XARST_i),
    .CK_EE_i   (CK_EE_i),
    .HVcy_i    (HVcy_i),
    .AUTO_EN_i (AUTO_EN_i),
    .HREQ_i    (HREQ_i),
    .HLEDs_i   (HLEDs_i),
    .HACK_o    (HACK_o),
    .LEDs_ON_o (LEDs_ON_o),
    .COMMIT_o  (COMMIT_o),
    .PEND_o    (PEND_o),
    .DROPs_o   (DROPs_o)
  );

  always #5 CK_i = ~CK_i;

  task automatic step();
    @(posedge CK_i);
    #1;
  endtask

  task automatic strobe();
    HVcy_i = 1'b1;
    step();
    HVcy_i = 1'b0;
  endtask

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    checks++;
    assert (obs === exp) else begin
      errors++;
      $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
    end
  endtask

  initial begin
    // Reset state
    step();
    step();
    chk("rst_leds", 32'(LEDs_ON_o), 32'h0);
    chk("rst_pend", 32'(PEND_o), 32'h0);
    chk("rst_hack", 32'(HACK_o), 32'h0);
    chk("rst_commit", 32'(COMMIT_o), 32'h0);
    chk("rst_drops", 32'(DROPs_o), 32'h0);
    XARST_i = 1'b1;
    step();

    // Three idle strobes: nothing commits
    for (int i = 0; i < 3; i++) begin
      strobe();
      chk("idle_commit", 32'(COMMIT_o), 32'h0);
      step();
      chk("idle_commit2", 32'(COMMIT_o), 32'h0);
    end
    chk("idle_leds", 32'(LEDs_ON_o), 32'h0);

    // Host update mid-frame
    HLEDs_i = 18'h2AAAA;
    HREQ_i  = 1'b1;
    step();
    chk("host_hack", 32'(HACK_o), 32'h1);
    chk("host_pend", 32'(PEND_o), 32'h1);
    chk("host_leds_hold", 32'(LEDs_ON_o), 32'h0);
    HREQ_i = 1'b0;
    step();
    chk("host_hack_1cyc", 32'(HACK_o), 32'h0);
    chk("host_leds_hold2", 32'(LEDs_ON_o), 32'h0);
    strobe();
    chk("host_leds", 32'(LEDs_ON_o), 32'h2AAAA);
    chk("host_commit", 32'(COMMIT_o), 32'h1);
    chk("host_pend_clr", 32'(PEND_o), 32'h0);
    step();
    chk("host_commit_1cyc", 32'(COMMIT_o), 32'h0);

    // Clock enable low across a strobe, then reset while host-pending
    HLEDs_i = 18'h00155;
    HREQ_i  = 1'b1;
    step();
    HREQ_i = 1'b0;
    chk("ce_pend", 32'(PEND_o), 32'h1);
    step();
    CK_EE_i = 1'b0;
    strobe();
    chk("ce_leds", 32'(LEDs_ON_o), 32'h2AAAA);
    chk("ce_commit", 32'(COMMIT_o), 32'h0);
    chk("ce_pend_hold", 32'(PEND_o), 32'h1);
    step();
    CK_EE_i = 1'b1;
    #2;
    XARST_i = 1'b0;
    #1;
    chk("arst_leds", 32'(LEDs_ON_o), 32'h0);
    chk("arst_pend", 32'(PEND_o), 32'h0);
    step();
    XARST_i = 1'b1;
    step();

    // Walking LED with period 2
    AUTO_EN_i = 1'b1;
    strobe();
    chk("auto_s1_pend", 32'(PEND_o), 32'h0);
    step();
    strobe();
    chk("auto_s2_pend", 32'(PEND_o), 32'h1);
    chk("auto_s2_leds", 32'(LEDs_ON_o), 32'h0);
    step();
    strobe();
    chk("auto_s3_leds", 32'(LEDs_ON_o), 32'h00001);
    chk("auto_s3_commit", 32'(COMMIT_o), 32'h1);
    step();
    strobe();
    step();
    strobe();
    chk("auto_s5_leds", 32'(LEDs_ON_o), 32'h00002);
    step();
    for (int k = 3; k <= 18; k++) begin
      strobe();
      step();
      strobe();
      step();
      chk("auto_walk", 32'(LEDs_ON_o), 32'h1 << (k - 1));
    end
    strobe();
    step();
    strobe();
    step();
    chk("auto_wrap", 32'(LEDs_ON_o), 32'h00001);

    // Host overrides a pending auto step, then an auto step hits a host pend
    strobe();
    chk("ovr_auto_pend", 32'(PEND_o), 32'h1);
    HLEDs_i = 18'h12345;
    HREQ_i  = 1'b1;
    step();
    HREQ_i = 1'b0;
    chk("ovr_hack", 32'(HACK_o), 32'h1);
    chk("ovr_drops1", 32'(DROPs_o), 32'h1);
    step();
    strobe();
    chk("ovr_leds", 32'(LEDs_ON_o), 32'h12345);
    chk("ovr_drops1b", 32'(DROPs_o), 32'h1);
    step();
    HLEDs_i = 18'h0F0F0;
    HREQ_i  = 1'b1;
    step();
    HREQ_i = 1'b0;
    chk("hp_hack", 32'(HACK_o), 32'h1);
    step();
    strobe();
    chk("hp_leds", 32'(LEDs_ON_o), 32'h0F0F0);
    chk("hp_commit", 32'(COMMIT_o), 32'h1);
    chk("hp_drops2", 32'(DROPs_o), 32'h2);
    step();

    // Disabling auto mode cancels a pending auto step without a drop
    strobe();
    step();
    strobe();
    chk("cancel_pend", 32'(PEND_o), 32'h1);
    AUTO_EN_i = 1'b0;
    step();
    chk("cancel_idle", 32'(PEND_o), 32'h0);
    chk("cancel_drops", 32'(DROPs_o), 32'h2);
    strobe();
    chk("cancel_leds", 32'(LEDs_ON_o), 32'h0F0F0);
    chk("cancel_commit", 32'(COMMIT_o), 32'h0);
    step();

    // Host acceptance coinciding with a strobe: capture only
    HLEDs_i = 18'h3FFFF;
    HREQ_i  = 1'b1;
    HVcy_i  = 1'b1;
    step();
    HREQ_i = 1'b0;
    HVcy_i = 1'b0;
    chk("coin_hack", 32'(HACK_o), 32'h1);
    chk("coin_pend", 32'(PEND_o), 32'h1);
    chk("coin_commit", 32'(COMMIT_o), 32'h0);
    chk("coin_leds_hold", 32'(LEDs_ON_o), 32'h0F0F0);
    step();
    strobe();
    chk("coin_leds", 32'(LEDs_ON_o), 32'h3FFFF);
    chk("coin_commit2", 32'(COMMIT_o), 32'h1);

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
